spi_master_phy: RTL and testbench

Parametrised SPI master physical layer with configurable word width, slave count, SCLK divider, and all four SPI modes (CPOL/CPHA) selectable per frame. It supports back-to-back words with chip-select held between them. It sits between the word-level transfer logic and the SPI pins, and supersedes the fixed 8-bit, mode-0 `spi_phy`.

---
 rtl/spi_master_phy_if.sv | 27 ++
 rtl/spi_master_phy.sv | 197 +++++++++++++++++++
 tb/tb_spi_master_phy.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_phy_if.sv
// Word-level side of the SPI master PHY: transfer request, transmit word and
// receive word with their one-cycle strobes, plus the busy flag.
interface spi_master_phy_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 1
);
  logic              enable;
  logic [1:0]        mode;          // {CPOL, CPHA}
  logic [SEL_W-1:0]  slave_sel;
  logic [DATA_W-1:0] word_in;
  logic              word_written;
  logic [DATA_W-1:0] word_out;
  logic              word_valid;
  logic              busy;

  // master: the word-level transfer logic driving the PHY
  modport master (
    output enable, mode, slave_sel, word_in,
    input  word_written, word_out, word_valid, busy
  );

  // slave: the PHY itself
  modport slave (
    input  enable, mode, slave_sel, word_in,
    output word_written, word_out, word_valid, busy
  );
endinterface

// File: rtl/spi_master_phy.sv
// SPI master PHY: all four CPOL/CPHA modes, back-to-back words under one chip select.
// Define SPI_PHY_LSB_FIRST_EN for LSB-first transmission and reception (default MSB first).
module spi_master_phy #(
  parameter int DATA_W   = 8,
  parameter int N_SLAVES = 2,
  parameter int CLK_DIV  = 2
) (
  input  logic                clk_in,
  input  logic                reset,
  spi_master_phy_if.slave     bus,
  output logic                sclk,
  output logic [N_SLAVES-1:0] cs,
  output logic                mosi,
  input  logic                miso
);

  localparam int HC_W = $clog2(CLK_DIV + 1);
  localparam int BC_W = $clog2(2 * DATA_W + 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t              r_state;
  logic [HC_W-1:0]     r_hc;
  logic [BC_W-1:0]     r_bc;
  logic [1:0]          r_mode;
  logic [DATA_W-1:0]   r_tx;
  logic [DATA_W-1:0]   r_rx;
  logic [DATA_W-1:0]   r_word_out;
  logic                r_sclk;
  logic [N_SLAVES-1:0] r_cs;
  logic                r_mosi;
  logic                r_word_valid;
  logic                r_word_written;
  logic                r_busy;

  logic                w_hc_end;
  logic                w_last_edge;
  logic                w_sample;
  logic [DATA_W-1:0]   w_rx_next;
  logic [N_SLAVES-1:0] w_cs_sel;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
`ifdef SPI_PHY_LSB_FIRST_EN
    return w[0];
`else
    return w[DATA_W-1];
`endif
  endfunction

  function automatic logic [DATA_W-1:0] drop_first(input logic [DATA_W-1:0] w);
`ifdef SPI_PHY_LSB_FIRST_EN
    return w >> 1;
`else
    return w << 1;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
`ifdef SPI_PHY_LSB_FIRST_EN
    return {b, w[DATA_W-1:1]};
`else
    return {w[DATA_W-2:0], b};
`endif
  endfunction

  assign w_hc_end    = (r_hc == HC_LAST);
  assign w_last_edge = (r_bc == BC_LAST);
  // Edge number is r_bc+1; CPHA=0 samples odd edges, CPHA=1 samples even edges.
  assign w_sample    = ~r_bc[0] ^ r_mode[0];
  assign w_rx_next   = w_sample ? shift_in(r_rx, miso) : r_rx;

  // An out-of-range slave_sel matches no index, so every chip select stays high.
  always_comb begin
    w_cs_sel = '1;
    for (int i = 0; i < N_SLAVES; i++) begin
      w_cs_sel[i] = (int'(bus.slave_sel) != i);
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // updates from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_hc           <= '0;
      r_bc           <= '0;
      r_mode         <= 2'b00;
      r_tx           <= '0;
      r_rx           <= '0;
      r_word_out     <= '0;
      r_sclk         <= 1'b0;
      r_cs           <= '1;
      r_mosi         <= 1'b0;
      r_word_valid   <= 1'b0;
      r_word_written <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_word_written <= 1'b0;
      r_word_valid   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sclk <= bus.mode[1];
          r_mosi <= 1'b0;
          r_cs   <= '1;
          if (bus.enable) begin
            r_state        <= SETUP;
            r_hc           <= '0;
            r_mode         <= bus.mode;
            r_cs           <= w_cs_sel;
            r_word_written <= 1'b1;
            r_busy         <= 1'b1;
            if (!bus.mode[0]) begin
              r_mosi <= first_bit(bus.word_in);
              r_tx   <= drop_first(bus.word_in);
            end else begin
              r_tx   <= bus.word_in;
            end
          end
        end
        SETUP: begin
          if (w_hc_end) begin
            r_state <= SHIFT;
            r_hc    <= '0;
            r_bc    <= '0;
          end else begin
            r_hc <= r_hc + 1'b1;
          end
        end
        SHIFT: begin
          if (!w_hc_end) begin
            r_hc <= r_hc + 1'b1;
          end else begin
            r_hc   <= '0;
            r_sclk <= ~r_sclk;
            r_rx   <= w_rx_next;
            if (!w_sample) begin
              r_mosi <= first_bit(r_tx);
              r_tx   <= drop_first(r_tx);
            end
            if (!w_last_edge) begin
              r_bc <= r_bc + 1'b1;
            end else begin
              r_bc         <= '0;
              r_word_out   <= w_rx_next;
              r_word_valid <= 1'b1;
              if (bus.enable) begin
                // Continue straight into the next word; the final edge was a
                // shift edge for CPHA=0, so its first bit goes out now.
                r_word_written <= 1'b1;
                if (!r_mode[0]) begin
                  r_mosi <= first_bit(bus.word_in);
                  r_tx   <= drop_first(bus.word_in);
                end else begin
                  r_tx   <= bus.word_in;
                end
              end else begin
                r_state <= HOLD;
                r_sclk  <= r_mode[1];
              end
            end
          end
        end
        HOLD: begin
          if (w_hc_end) begin
            r_state <= GAP;
            r_hc    <= '0;
            r_cs    <= '1;
          end else begin
            r_hc <= r_hc + 1'b1;
          end
        end
        GAP: begin
          if (w_hc_end) begin
            r_state <= IDLE;
            r_hc    <= '0;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_hc <= r_hc + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sclk             = r_sclk;
  assign cs               = r_cs;
  assign mosi             = r_mosi;
  assign bus.word_out     = r_word_out;
  assign bus.word_valid   = r_word_valid;
  assign bus.word_written = r_word_written;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_spi_master_phy.sv
// Scoreboard bench for spi_master_phy: expected words are queued at stimulus
// time and popped by a monitor on every word_valid; timing checked per frame.
module tb_spi_master_phy;
  localparam int DATA_W   = 8;
  localparam int N_SLAVES = 3;   // SEL_W = 2 so an out-of-range index (3) is expressible
  localparam int CLK_DIV  = 2;

  logic                clk_in = 1'b0;
  logic                reset  = 1'b0;
  logic                sclk;
  logic [N_SLAVES-1:0] cs;
  logic                mosi;
  logic                miso;

  spi_master_phy_if #(.DATA_W(DATA_W), .SEL_W(2)) bus ();

  spi_master_phy #(.DATA_W(DATA_W), .N_SLAVES(N_SLAVES), .CLK_DIV(CLK_DIV)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus),
    .sclk   (sclk),
    .cs     (cs),
    .mosi   (mosi),
    .miso   (miso)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Slave model: drives miso per CPHA and captures mosi on its sampling edges.
  logic              loop_en  = 1'b0;
  logic              slv_cpha = 1'b0;
  logic [7:0]        slv_tx   = '0;
  logic [7:0]        slv_rx   = '0;
  logic              slv_miso = 1'b0;
  logic              slv_prev = 1'b0;
  int                edge_cnt = 0;

  assign miso = loop_en ? mosi : slv_miso;

  always @(negedge clk_in) begin
    int b;
    if (&cs) begin
      edge_cnt = 0;
      slv_rx   = '0;
    end else if (sclk !== slv_prev) begin
      edge_cnt++;
      if ((edge_cnt % 2 == 1) != slv_cpha) begin
`ifdef SPI_PHY_LSB_FIRST_EN
        slv_rx = {mosi, slv_rx[7:1]};
`else
        slv_rx = {slv_rx[6:0], mosi};
`endif
      end
    end
    slv_prev = sclk;
    if (slv_cpha) b = (edge_cnt == 0) ? 0 : (edge_cnt - 1) / 2;
    else          b = edge_cnt / 2;
    if (b > 7) b = 7;
`ifdef SPI_PHY_LSB_FIRST_EN
    slv_miso = slv_tx[b];
`else
    slv_miso = slv_tx[7-b];
`endif
  end

  // Monitor: every word_valid pops one expectation.
  always @(negedge clk_in) begin
    if (reset && bus.word_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_word_valid", 32'd1, 32'd0);
      else                   check("word_out", 32'(bus.word_out), 32'(exp_q.pop_front()));
    end
  end

  function automatic logic exp_first(input logic [7:0] w);
`ifdef SPI_PHY_LSB_FIRST_EN
    return w[0];
`else
    return w[7];
`endif
  endfunction

  // Per-frame measurements, cycle n = n-th sample after the enable-sampling edge.
  int         f_busy, f_cs_low, f_other_low, f_toggles, f_rises, f_ww, f_wv;
  logic       f_first_mosi;
  logic [7:0] f_srx;

  task automatic run_frame(input logic [1:0] m, input logic [1:0] sel, input logic [7:0] w,
                           input bit lp, input logic [7:0] slave_word);
    logic [2:0] sel_mask;
    logic       prev;
    sel_mask = (sel < 2'd3) ? (3'b001 << sel) : 3'b000;
    @(negedge clk_in); #1;
    bus.mode = m; bus.slave_sel = sel; bus.word_in = w;
    loop_en = lp; slv_cpha = m[0]; slv_tx = slave_word;
    repeat (3) @(negedge clk_in);
    #1;
    check("idle_sclk_cpol", 32'(sclk), 32'(m[1]));
    exp_q.push_back(lp ? w : slave_word);
    bus.enable = 1'b1;
    f_busy = 0; f_cs_low = 0; f_other_low = 0; f_toggles = 0; f_rises = 0;
    f_ww = -1; f_wv = -1; f_first_mosi = 1'bx; f_srx = 'x;
    prev = sclk;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk_in); #1;
      if (n == 1) begin
        bus.enable   = 1'b0;
        f_first_mosi = mosi;
      end
      if (bus.busy) f_busy++;
      if ((sel_mask != 3'b000) && ((cs & sel_mask) == 3'b000)) f_cs_low++;
      if ((cs | sel_mask) != 3'b111) f_other_low++;
      if (sclk !== prev) f_toggles++;
      if (sclk === 1'b1 && prev === 1'b0) f_rises++;
      prev = sclk;
      if (bus.word_written && f_ww < 0) f_ww = n;
      if (bus.word_valid && f_wv < 0) begin
        f_wv  = n;
        f_srx = slv_rx;
      end
      if (!bus.busy && n > 1) break;
      if (n == 200) check("frame_timeout", 32'd1, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ww_cycles[3];
    int nww, b_busy, b_cs_low, b_toggles;
    logic prev;

    bus.enable = 1'b0; bus.mode = 2'b00; bus.slave_sel = '0; bus.word_in = '0;
    repeat (3) @(negedge clk_in);
    check("rst_sclk",  32'(sclk), 32'd0);
    check("rst_cs",    32'(cs), 32'b111);
    check("rst_mosi",  32'(mosi), 32'd0);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_ww",    32'(bus.word_written), 32'd0);
    check("rst_wv",    32'(bus.word_valid), 32'd0);
    check("rst_wout",  32'(bus.word_out), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk_in);

    // Mode 0, loopback, 8'h55 on slave 0.
    run_frame(2'b00, 2'd0, 8'h55, 1'b1, 8'h00);
    check("m0_ww_cycle",   32'(f_ww), 32'd1);
    check("m0_first_mosi", 32'(f_first_mosi), 32'(exp_first(8'h55)));
    check("m0_cs_low",     32'(f_cs_low), 32'd36);
    check("m0_sclk_rises", 32'(f_rises), 32'd8);
    check("m0_wv_cycle",   32'(f_wv), 32'd35);
    check("m0_busy",       32'(f_busy), 32'd38);
    check("m0_slave_rx",   32'(f_srx), 32'h55);

    // Modes 1..3 on slave 1, slave returning 8'hA3.
    for (int m = 1; m < 4; m++) begin
      run_frame(2'(m), 2'd1, 8'h3C, 1'b0, 8'hA3);
      check($sformatf("m%0d_slave_rx", m), 32'(f_srx), 32'h3C);
      check($sformatf("m%0d_cs0_high", m), 32'(f_other_low), 32'd0);
      check($sformatf("m%0d_cs1_low", m), 32'(f_cs_low), 32'd36);
      check($sformatf("m%0d_toggles", m), 32'(f_toggles), 32'd16);
      check($sformatf("m%0d_busy", m), 32'(f_busy), 32'd38);
    end

    // Back-to-back: three words under one chip select.
    @(negedge clk_in); #1;
    bus.mode = 2'b00; bus.slave_sel = 2'd0; bus.word_in = 8'h01; loop_en = 1'b1; slv_cpha = 1'b0;
    repeat (3) @(negedge clk_in);
    #1;
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    bus.enable = 1'b1;
    nww = 0; b_busy = 0; b_cs_low = 0; b_toggles = 0;
    prev = sclk;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk_in); #1;
      if (bus.word_written) begin
        if (nww < 3) ww_cycles[nww] = n;
        nww++;
        if (nww == 1) bus.word_in = 8'h02;
        if (nww == 2) bus.word_in = 8'h03;
        if (nww == 3) bus.enable = 1'b0;
      end
      if (bus.busy) b_busy++;
      if (!cs[0]) b_cs_low++;
      if (sclk !== prev) b_toggles++;
      prev = sclk;
      if (!bus.busy && n > 1) break;
      if (n == 300) check("b2b_timeout", 32'd1, 32'd0);
    end
    check("b2b_ww_count", 32'(nww), 32'd3);
    check("b2b_ww2",      32'(ww_cycles[1]), 32'd35);
    check("b2b_period",   32'(ww_cycles[2] - ww_cycles[1]), 32'd32);
    check("b2b_cs_low",   32'(b_cs_low), 32'd100);
    check("b2b_toggles",  32'(b_toggles), 32'd48);
    check("b2b_busy",     32'(b_busy), 32'd102);

    // Reset asserted at bit 4 of a frame.
    @(negedge clk_in); #1;
    bus.mode = 2'b00; bus.slave_sel = 2'd0; bus.word_in = 8'h96; loop_en = 1'b1;
    repeat (3) @(negedge clk_in);
    #1;
    bus.enable = 1'b1;
    b_toggles = 0;
    prev = sclk;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk_in); #1;
      bus.enable = 1'b0;
      if (sclk !== prev) b_toggles++;
      prev = sclk;
      if (b_toggles == 8) break;
      if (n == 100) check("rst_mid_timeout", 32'd1, 32'd0);
    end
    reset = 1'b0;
    #1;
    check("mid_rst_sclk", 32'(sclk), 32'd0);
    check("mid_rst_cs",   32'(cs), 32'b111);
    check("mid_rst_mosi", 32'(mosi), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_wout", 32'(bus.word_out), 32'd0);
    repeat (4) @(negedge clk_in);
    #1;
    reset = 1'b1;
    repeat (40) @(negedge clk_in);
    run_frame(2'b00, 2'd0, 8'h5A, 1'b1, 8'h00);
    check("post_rst_busy", 32'(f_busy), 32'd38);
    check("post_rst_wv",   32'(f_wv), 32'd35);

    // Out-of-range slave index: no chip select, word still completes.
    run_frame(2'b00, 2'd3, 8'hC6, 1'b1, 8'h00);
    check("oor_cs_high", 32'(f_other_low), 32'd0);
    check("oor_wv",      32'(f_wv), 32'd35);

    // LSB-or-MSB first-bit check with 8'h01.
    run_frame(2'b00, 2'd0, 8'h01, 1'b1, 8'h00);
    check("w01_first_mosi", 32'(f_first_mosi), 32'(exp_first(8'h01)));

    repeat (5) @(negedge clk_in);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
